// File: rtl/calci_arbiter.sv
// calci_arbiter
//   Round-robin front end that shares one 8-bit calculator between NREQ
//   requesters. A single registered issue stage drives the calculator
//   (Valid/A/B/ctrl) and holds steady while Stall is high. Each accepted
//   operation's requester ID rides a LATENCY-deep tag pipeline and is
//   paired with the calculator result C when it comes out the far end.
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   req_valid/a/b/ctrl      per-requester operation (packed, requester i at
//                           [8i+7:8i] / [2i+1:2i])
//   req_ready               one-hot combinational grant
//   Valid, A, B, ctrl       issue stage towards the calculator
//   Stall                   calculator back-pressure
//   C                       calculator result
//   rsp_valid/id/c          registered result pulse with owning requester
//   inflight                operations accepted but not yet returned
module calci_arbiter #(
    parameter int NREQ    = 4,
    parameter int LATENCY = 2,
    parameter int IDW     = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*8-1:0]    req_a,
    input  logic [NREQ*8-1:0]    req_b,
    input  logic [NREQ*2-1:0]    req_ctrl,
    output logic [NREQ-1:0]      req_ready,
    output logic                 Valid,
    output logic [7:0]           A,
    output logic [7:0]           B,
    output logic [1:0]           ctrl,
    input  logic                 Stall,
    input  logic [15:0]          C,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [15:0]          rsp_c,
    output logic [IDW+1:0]       inflight
);

    // Flat operand buses viewed as per-requester lanes.
    logic [NREQ-1:0][7:0] a_vec;
    logic [NREQ-1:0][7:0] b_vec;
    logic [NREQ-1:0][1:0] ctrl_vec;

    assign a_vec    = req_a;
    assign b_vec    = req_b;
    assign ctrl_vec = req_ctrl;

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] issue_id;
    logic           free;
    logic           accept;
    logic           grant_found;
    logic [IDW-1:0] grant_idx;
    logic [IDW-1:0] ptr_next;
    int             cand;

    // Tag pipeline: vld_pipe[s]/id_pipe[s] is the tag s+1 edges after accept.
    logic [LATENCY-1:0]          vld_pipe;
    logic [LATENCY-1:0][IDW-1:0] id_pipe;
    logic                        retire;

    assign free   = !Valid || !Stall;
    assign accept = Valid && !Stall;
    assign retire = vld_pipe[LATENCY-1];

    // Scan from the pointer upward with wrap; first active requester wins.
    always_comb begin
        req_ready   = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        if (rst_n && free) begin
            for (int k = 0; k < NREQ; k++) begin
                cand = (int'(ptr) + k) % NREQ;
                if (!grant_found && req_valid[IDW'(cand)]) begin
                    grant_found = 1'b1;
                    grant_idx   = IDW'(cand);
                end
            end
            if (grant_found)
                req_ready[grant_idx] = 1'b1;
        end
    end

    assign ptr_next = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            Valid     <= 1'b0;
            A         <= '0;
            B         <= '0;
            ctrl      <= '0;
            issue_id  <= '0;
            ptr       <= '0;
            vld_pipe  <= '0;
            id_pipe   <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_c     <= '0;
            inflight  <= '0;
        end else begin
            // Issue stage: reload when free, otherwise hold under stall.
            if (free) begin
                if (grant_found) begin
                    Valid    <= 1'b1;
                    A        <= a_vec[grant_idx];
                    B        <= b_vec[grant_idx];
                    ctrl     <= ctrl_vec[grant_idx];
                    issue_id <= grant_idx;
                    ptr      <= ptr_next;
                end else begin
                    Valid <= 1'b0;
                end
            end

            // Tag pipeline advances every cycle regardless of Stall.
            vld_pipe[0] <= accept;
            id_pipe[0]  <= issue_id;
            for (int s = 1; s < LATENCY; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                id_pipe[s]  <= id_pipe[s-1];
            end

            rsp_valid <= retire;
            if (retire) begin
                rsp_id <= id_pipe[LATENCY-1];
                rsp_c  <= C;
            end

            case ({accept, retire})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

endmodule

// File: tb/tb_calci_arbiter.sv
module tb_calci_arbiter;
    localparam int NREQ    = 4;
    localparam int LATENCY = 2;
    localparam int IDW     = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0][7:0]  sa, sb;
    logic [NREQ-1:0][1:0]  sc;
    logic [NREQ-1:0]       req_ready;
    logic                  Valid;
    logic [7:0]            A, B;
    logic [1:0]            ctrl;
    logic                  Stall;
    logic [15:0]           C;
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic [15:0]           rsp_c;
    logic [IDW+1:0]        inflight;

    always #5 clk = ~clk;

    calci_arbiter #(.NREQ(NREQ), .LATENCY(LATENCY), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_a(sa), .req_b(sb), .req_ctrl(sc),
        .req_ready(req_ready),
        .Valid(Valid), .A(A), .B(B), .ctrl(ctrl), .Stall(Stall), .C(C),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_c(rsp_c),
        .inflight(inflight)
    );

    // Reference model: pending responses are a queue of (id, due edge).
    typedef struct { int id; int due; } tag_t;
    tag_t q[$];

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    bit          m_valid  = 0;
    logic [7:0]  m_a = 0, m_b = 0;
    logic [1:0]  m_ctrl = 0;
    int          m_id = 0, m_ptr = 0;
    bit          m_rv = 0;
    int          m_rid = 0;
    logic [15:0] m_rc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Called just after a negedge with inputs already driven.
    task automatic step();
        int g;
        bit acc;
        logic [NREQ-1:0] er;
        #1;
        g = -1;
        if (rst_n && (!m_valid || !Stall))
            for (int k = 0; k < NREQ; k++)
                if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("Valid", 32'(Valid), 32'(m_valid));
        if (m_valid) begin
            chk("A", 32'(A), 32'(m_a));
            chk("B", 32'(B), 32'(m_b));
            chk("ctrl", 32'(ctrl), 32'(m_ctrl));
        end
        chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
        chk("rsp_id", 32'(rsp_id), 32'(m_rid));
        chk("rsp_c", 32'(rsp_c), 32'(m_rc));
        chk("inflight", 32'(inflight), 32'(q.size()));

        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            q.delete();
            m_valid = 0; m_a = 0; m_b = 0; m_ctrl = 0; m_id = 0; m_ptr = 0;
            m_rv = 0; m_rid = 0; m_rc = 0;
        end else begin
            acc  = m_valid && !Stall;
            m_rv = 0;
            if (q.size() > 0 && q[0].due == cyc) begin
                m_rv  = 1;
                m_rid = q[0].id;
                m_rc  = C;
                void'(q.pop_front());
            end
            if (acc) q.push_back('{m_id, cyc + LATENCY});
            if (!m_valid || !Stall) begin
                if (g >= 0) begin
                    m_valid = 1; m_a = sa[g]; m_b = sb[g]; m_ctrl = sc[g];
                    m_id = g; m_ptr = (g + 1) % NREQ;
                end else begin
                    m_valid = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic [NREQ-1:0] v, input logic st, input int n);
        req_valid = v;
        Stall     = st;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst_n = 0; req_valid = '0; Stall = 0; C = 16'h0;
        for (int i = 0; i < NREQ; i++) begin
            sa[i] = 8'(8'h10 + i); sb[i] = 8'(8'h20 + i); sc[i] = 2'(i);
        end
        // Settle the DUT through one reset edge before checking anything.
        @(posedge clk);
        @(negedge clk);

        // Reset with every requester active.
        drive('1, 1'b0, 3);
        rst_n = 1;

        // Round-robin with all requesters active.
        drive('1, 1'b0, 9);
        drive('0, 1'b0, 4);

        // Stall hold on requester 2, then release and return C.
        C = 16'h002D;
        sa[2] = 8'h0F; sb[2] = 8'h03; sc[2] = 2'b10;
        drive(4'b0100, 1'b0, 1);
        drive('1, 1'b1, 5);
        drive('0, 1'b0, 5);

        // Sparse: only requester 3 with pointer at 0, then requester 1.
        rst_n = 0; drive('0, 1'b0, 1); rst_n = 1;
        drive(4'b1000, 1'b0, 1);
        drive(4'b0000, 1'b0, 1);
        drive(4'b0010, 1'b0, 1);
        drive('0, 1'b0, 4);

        // Pipelined return: requesters 1 then 3 on consecutive edges.
        rst_n = 0; drive('0, 1'b0, 1); rst_n = 1;
        C = 16'hBEEF;
        drive(4'b0010, 1'b0, 1);
        drive(4'b1000, 1'b0, 1);
        drive('0, 1'b0, 5);

        // Reset one cycle after an accept: the response must never appear.
        drive(4'b0001, 1'b0, 1);
        drive(4'b0000, 1'b0, 1);
        rst_n = 0; drive('0, 1'b0, 1); rst_n = 1;
        drive('0, 1'b0, 5);

        // Randomized traffic with occasional stalls and resets.
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                sa[i] = 8'($urandom); sb[i] = 8'($urandom); sc[i] = 2'($urandom);
            end
            req_valid = NREQ'($urandom);
            Stall     = ($urandom_range(0, 9) < 3);
            C         = 16'($urandom);
            rst_n     = ($urandom_range(0, 99) >= 2);
            step();
        end
        rst_n = 1;
        drive('0, 1'b0, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
